// File: rtl/biu_pkg.sv
// -----------------------------------------------------------------------------
// biu_pkg
// Shared definitions for the bus-interface-unit request path: transfer size
// encodings, arbiter FSM state type and default bus widths.
// -----------------------------------------------------------------------------
package biu_pkg;

    // One-hot transfer size encodings carried on *_size.
    localparam logic [3:0] SZ_B = 4'b0001;
    localparam logic [3:0] SZ_H = 4'b0010;
    localparam logic [3:0] SZ_W = 4'b0100;
    localparam logic [3:0] SZ_D = 4'b1000;

    // Request arbiter states.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // Default widths of the cache_bus_unit request interface.
    localparam int BIU_PA_W   = 64;
    localparam int BIU_DATA_W = 64;
    localparam int BIU_CNT_W  = 11;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns the one-hot grant of the first
// asserted request at or after index ptr, wrapping modulo N.
//
// Ports:
//   req  in  N      request vector
//   ptr  in  PTR_W  highest-priority index for this pick (must be < N)
//   gnt  out N      one-hot grant (all zero when nothing requests)
//   any  out 1      at least one request asserted
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             any
);

    logic [N-1:0] hi_gnt;
    logic [N-1:0] lo_gnt;
    logic         hi_found;
    logic         lo_found;

    // Two priority scans instead of a rotate: the first requester at or above
    // ptr wins; if there is none, the search wraps to the lowest requester.
    always_comb begin
        hi_gnt   = '0;
        lo_gnt   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !hi_found && (PTR_W'(i) >= ptr)) begin
                hi_gnt[i] = 1'b1;
                hi_found  = 1'b1;
            end
            if (req[i] && !lo_found) begin
                lo_gnt[i] = 1'b1;
                lo_found  = 1'b1;
            end
        end
        gnt = hi_found ? hi_gnt : lo_gnt;
    end

    assign any = |req;

endmodule

// File: rtl/biu_req_arbiter.sv
// -----------------------------------------------------------------------------
// biu_req_arbiter
// Round-robin, transaction-atomic arbiter placing NUM_CH cache-controller
// channels onto the single cache_bus_unit request port, with per-channel
// routing of the bus unit's responses.
//
// A channel owns the bus from grant until bu_trans_rdy / bu_bus_error; one
// RELEASE cycle with requests forced low follows so the owner can drop its
// request before the next arbitration.
//
// Optional build macro:
//   BIU_ARB_TIMEOUT_EN  watchdog: a transaction without response for
//                       TIMEOUT_CYC BUSY cycles ends with a one-cycle
//                       ch_bus_error on the owner. Undefined: no watchdog.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ch_wt_req/read_req/read_line_req [NUM_CH]   per-channel requests
//   ch_size [4*NUM_CH], ch_pa [PA_W*NUM_CH], ch_wt_data [DATA_W*NUM_CH]
//                            per-channel request fields
//   ch_line_data, ch_addr_count   bus-unit line data / word index, broadcast
//   ch_line_write, ch_cache_entry_write, ch_trans_rdy, ch_bus_error [NUM_CH]
//                            response strobes, owner bit only
//   bu_wt_req, bu_read_req, bu_read_line_req, bu_size, bu_pa, bu_wt_data
//                            request forwarded to cache_bus_unit
//   bu_line_data, bu_addr_count, bu_line_write, bu_cache_entry_write,
//   bu_trans_rdy, bu_bus_error    responses from cache_bus_unit
//   grant [NUM_CH]           one-hot current owner
// -----------------------------------------------------------------------------
module biu_req_arbiter
    import biu_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int PA_W        = BIU_PA_W,
    parameter int DATA_W      = BIU_DATA_W,
    parameter int CNT_W       = BIU_CNT_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [NUM_CH-1:0]        ch_wt_req,
    input  logic [NUM_CH-1:0]        ch_read_req,
    input  logic [NUM_CH-1:0]        ch_read_line_req,
    input  logic [4*NUM_CH-1:0]      ch_size,
    input  logic [PA_W*NUM_CH-1:0]   ch_pa,
    input  logic [DATA_W*NUM_CH-1:0] ch_wt_data,
    output logic [DATA_W-1:0]        ch_line_data,
    output logic [CNT_W-1:0]         ch_addr_count,
    output logic [NUM_CH-1:0]        ch_line_write,
    output logic [NUM_CH-1:0]        ch_cache_entry_write,
    output logic [NUM_CH-1:0]        ch_trans_rdy,
    output logic [NUM_CH-1:0]        ch_bus_error,

    output logic                     bu_wt_req,
    output logic                     bu_read_req,
    output logic                     bu_read_line_req,
    output logic [3:0]               bu_size,
    output logic [PA_W-1:0]          bu_pa,
    output logic [DATA_W-1:0]        bu_wt_data,
    input  logic [DATA_W-1:0]        bu_line_data,
    input  logic [CNT_W-1:0]         bu_addr_count,
    input  logic                     bu_line_write,
    input  logic                     bu_cache_entry_write,
    input  logic                     bu_trans_rdy,
    input  logic                     bu_bus_error,

    output logic [NUM_CH-1:0]        grant
);

    localparam int PTR_W = $clog2(NUM_CH);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [NUM_CH-1:0]   grant_q;
    logic [NUM_CH-1:0]   grant_nxt;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    rr_ptr_nxt;
    logic [PTR_W-1:0]    gidx;
    logic [NUM_CH-1:0]   ch_any_req;
    logic [NUM_CH-1:0]   pick_gnt;
    logic                pick_any;
    logic                busy;
    logic                tmo_fire;
    logic                xact_done;

    assign ch_any_req = ch_wt_req | ch_read_req | ch_read_line_req;
    assign busy       = (state == ARB_BUSY);

    rr_pick #(
        .N     (NUM_CH),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (ch_any_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    // Binary index of the current owner, used for the pointer update.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q[i]) begin
                gidx = PTR_W'(i);
            end
        end
    end

`ifdef BIU_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

    logic [TMO_W-1:0] tmo_cnt;

    // Held at zero outside BUSY, so it reads 0 on the first BUSY cycle and
    // TIMEOUT_CYC-1 on BUSY cycle TIMEOUT_CYC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (!busy) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A completion in the expiry cycle wins over the watchdog.
    assign tmo_fire = busy && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) && !bu_trans_rdy;
`else
    assign tmo_fire = 1'b0;
`endif

    assign xact_done = bu_trans_rdy | bu_bus_error | tmo_fire;

    // ---- FSM state register -------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

    // ---- FSM next state -----------------------------------------------------
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_q;
        rr_ptr_nxt = rr_ptr;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_gnt;
                    state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (xact_done) begin
                    // Grant drops entering RELEASE; the owner becomes the
                    // lowest priority for the next arbitration.
                    grant_nxt  = '0;
                    state_nxt  = ARB_RELEASE;
                    rr_ptr_nxt = (gidx == PTR_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
                end
            end
            ARB_RELEASE: begin
                grant_nxt = '0;
                state_nxt = ARB_IDLE;
            end
            default: begin
                grant_nxt = '0;
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // ---- Request mux and response routing -----------------------------------
    // Requests are forwarded live from the owner only while BUSY; in IDLE and
    // RELEASE the bus unit sees nothing, even if a channel still requests.
    always_comb begin
        bu_wt_req            = 1'b0;
        bu_read_req          = 1'b0;
        bu_read_line_req     = 1'b0;
        bu_size              = '0;
        bu_pa                = '0;
        bu_wt_data           = '0;
        ch_line_write        = '0;
        ch_cache_entry_write = '0;
        ch_trans_rdy         = '0;
        ch_bus_error         = '0;
        if (busy) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant_q[i]) begin
                    bu_wt_req        = ch_wt_req[i];
                    bu_read_req      = ch_read_req[i];
                    bu_read_line_req = ch_read_line_req[i];
                    bu_size          = ch_size[i*4 +: 4];
                    bu_pa            = ch_pa[i*PA_W +: PA_W];
                    bu_wt_data       = ch_wt_data[i*DATA_W +: DATA_W];
                end
            end
            ch_line_write        = grant_q & {NUM_CH{bu_line_write}};
            ch_cache_entry_write = grant_q & {NUM_CH{bu_cache_entry_write}};
            ch_trans_rdy         = grant_q & {NUM_CH{bu_trans_rdy}};
            ch_bus_error         = grant_q & {NUM_CH{bu_bus_error | tmo_fire}};
        end
    end

    // Line data and word index are qualified by ch_line_write on the channel
    // side, so they are broadcast without registering.
    assign ch_line_data  = bu_line_data;
    assign ch_addr_count = bu_addr_count;
    assign grant         = grant_q;

endmodule
